// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, opcode encodings and a reference evaluator.
// The arbiter passes opcodes through undecoded; only the ALU (outside) interprets them.
package alu_pkg;

   localparam int XLEN     = 32;
   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_IDLE = 4'b0000,
      ALU_ADD  = 4'b0001,
      ALU_SUB  = 4'b0010,
      ALU_SLL  = 4'b0011,
      ALU_SLT  = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_AND  = 4'b0110,
      ALU_OR   = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_op_e;

   localparam logic [ALU_OP_W-1:0] ALU_OP_IDLE = ALU_IDLE;

   function automatic logic [XLEN-1:0] alu_eval(input logic [XLEN-1:0]     a,
                                                input logic [XLEN-1:0]     b,
                                                input logic [ALU_OP_W-1:0] op);
      logic [XLEN-1:0] r;
      r = '0;
      case (op)
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_SLL: r = a << b[4:0];
         ALU_SLT: r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_XOR: r = a ^ b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_SRL: r = a >> b[4:0];
         ALU_SRA: r = XLEN'($signed(a) >>> b[4:0]);
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of the ALU arbiter.
// slave = arbiter side; master = requesters, ALU and result consumer.
interface alu_arbiter_if #(
   parameter int N_REQ = 2
);
   import alu_pkg::*;

   localparam int ID_W = $clog2(N_REQ) + 1;

   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ-1:0]          req_ready;
   logic [N_REQ*XLEN-1:0]     req_rs1;
   logic [N_REQ*XLEN-1:0]     req_rs2;
   logic [N_REQ*ALU_OP_W-1:0] req_op;

   logic [XLEN-1:0]           alu_rs1;
   logic [XLEN-1:0]           alu_rs2;
   logic [ALU_OP_W-1:0]       alu_op;
   logic [XLEN-1:0]           alu_rd;

   logic                      resp_valid;
   logic                      resp_ready;
   logic [ID_W-1:0]           resp_id;
   logic [XLEN-1:0]           resp_data;

   modport slave (
      input  req_valid, req_rs1, req_rs2, req_op, alu_rd, resp_ready,
      output req_ready, alu_rs1, alu_rs2, alu_op, resp_valid, resp_id, resp_data
   );

   modport master (
      output req_valid, req_rs1, req_rs2, req_op, alu_rd, resp_ready,
      input  req_ready, alu_rs1, alu_rs2, alu_op, resp_valid, resp_id, resp_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set req at or after ptr wins, wrapping at N_REQ.
module rr_arbiter #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]       req,
   input  logic [$clog2(N_REQ):0] ptr,
   output logic [N_REQ-1:0]       gnt,
   output logic [$clog2(N_REQ):0] gnt_idx,
   output logic                   any_gnt
);

   localparam int ID_W = $clog2(N_REQ) + 1;

   // NOTE: every output gets a default before any conditional assignment, so no latch is inferred.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      // Upper pass covers ptr..N_REQ-1; the lower pass supplies the wrap to 0..ptr-1.
      for (int i = 0; i < N_REQ; i++) begin
         if (!any_gnt && req[i] && (i >= int'(ptr))) begin
            any_gnt = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = ID_W'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!any_gnt && req[i]) begin
            any_gnt = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between N_REQ requesters with a tagged,
// registered response stage. Define ALU_ARB_PERF_EN to add saturating grant/stall counters.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int CNT_W = 16
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [N_REQ*CNT_W-1:0] perf_grant_cnt,
   output logic [CNT_W-1:0]       perf_stall_cnt
`endif
);

   localparam int ID_W = $clog2(N_REQ) + 1;

   if (N_REQ < 1 || N_REQ > 8 || CNT_W < 1) begin : g_bad_param
      $error("alu_arbiter: N_REQ must be 1..8 and CNT_W at least 1");
   end

   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     rr_ptr_nxt;
   logic [N_REQ-1:0]    gnt;
   logic [ID_W-1:0]     gnt_idx;
   logic                any_gnt;
   logic                accept;
   logic                grant;

   logic                resp_valid_q;
   logic [ID_W-1:0]     resp_id_q;
   logic [XLEN-1:0]     resp_data_q;

   logic [XLEN-1:0]     mux_rs1;
   logic [XLEN-1:0]     mux_rs2;
   logic [ALU_OP_W-1:0] mux_op;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req     (bus.req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   // No grant while reset is asserted: the result would be discarded anyway.
   assign accept        = rst_n && (!resp_valid_q || bus.resp_ready);
   assign grant         = accept && any_gnt;
   assign bus.req_ready = accept ? gnt : '0;

   assign rr_ptr_nxt = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

   always_comb begin
      mux_rs1 = '0;
      mux_rs2 = '0;
      mux_op  = ALU_OP_IDLE;
      if (grant) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
               mux_rs1 = bus.req_rs1[i*XLEN +: XLEN];
               mux_rs2 = bus.req_rs2[i*XLEN +: XLEN];
               mux_op  = bus.req_op[i*ALU_OP_W +: ALU_OP_W];
            end
         end
      end
   end

   assign bus.alu_rs1 = mux_rs1;
   assign bus.alu_rs2 = mux_rs2;
   assign bus.alu_op  = mux_op;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: resp_data/resp_id are reset too, not just the valid flag, so the idle bus reads zero.
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
         rr_ptr       <= '0;
      end else if (grant) begin
         resp_valid_q <= 1'b1;
         resp_id_q    <= gnt_idx;
         resp_data_q  <= bus.alu_rd;
         rr_ptr       <= rr_ptr_nxt;
      end else if (bus.resp_ready) begin
         resp_valid_q <= 1'b0;
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_data  = resp_data_q;

`ifdef ALU_ARB_PERF_EN
   logic [CNT_W-1:0] grant_cnt [N_REQ];
   logic [CNT_W-1:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant && gnt[i] && (grant_cnt[i] != '1)) grant_cnt[i] <= grant_cnt[i] + CNT_W'(1);
         end
         if ((|bus.req_valid) && !accept && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_perf_pack
      assign perf_grant_cnt[g*CNT_W +: CNT_W] = grant_cnt[g];
   end
   assign perf_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with N_REQ=2; a behavioural ALU closes the alu_* loop.
// Perf counter checks are compiled only when ALU_ARB_PERF_EN is defined.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int N_REQ = 2;
   localparam int CNT_W = 16;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   alu_arbiter_if #(.N_REQ(N_REQ)) bus ();

`ifdef ALU_ARB_PERF_EN
   logic [N_REQ*CNT_W-1:0] perf_grant_cnt;
   logic [CNT_W-1:0]       perf_stall_cnt;
`endif

   alu_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus)
`ifdef ALU_ARB_PERF_EN
      ,
      .perf_grant_cnt (perf_grant_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   assign bus.alu_rd = alu_eval(bus.alu_rs1, bus.alu_rs2, bus.alu_op);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [3:0] op);
      bus.req_rs1[i*32 +: 32] = rs1;
      bus.req_rs2[i*32 +: 32] = rs2;
      bus.req_op[i*4 +: 4]    = op;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  rr_ready [4];
      logic [1:0]  rr_id    [4];
      logic [31:0] rr_data  [4];
      rr_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
      rr_id    = '{2'd0, 2'd1, 2'd0, 2'd1};
      rr_data  = '{32'h0000_0003, 32'h0000_00f0, 32'h0000_0003, 32'h0000_00f0};
      total = 0;
      bad   = 0;

      // Reset held two edges with both requesters valid
      rst_n          = 1'b0;
      bus.req_valid  = 2'b11;
      bus.resp_ready = 1'b1;
      bus.req_rs1    = '0;
      bus.req_rs2    = '0;
      bus.req_op     = '0;
      step();
      check("rst_ready",   32'(bus.req_ready), 32'h0);
      check("rst_valid",   32'(bus.resp_valid), 32'h0);
      check("rst_data",    bus.resp_data, 32'h0);
      check("rst_id",      32'(bus.resp_id), 32'h0);
      check("rst_alu_op",  32'(bus.alu_op), 32'h0);
      step();
      check("rst_ready2",  32'(bus.req_ready), 32'h0);
      bus.req_valid = 2'b00;
      rst_n         = 1'b1;
      #1;
      check("idle_alu_rs1", bus.alu_rs1, 32'h0);

      // Single request from requester 0 (AND)
      set_req(0, 32'h0a17_0000, 32'hff0c_0000, 4'b0110);
      bus.req_valid = 2'b01;
      #1;
      check("single_ready",  32'(bus.req_ready), 32'h1);
      check("single_alu_op", 32'(bus.alu_op), 32'h6);
      check("single_rs1",    bus.alu_rs1, 32'h0a17_0000);
      step();
      bus.req_valid = 2'b00;
      check("single_valid", 32'(bus.resp_valid), 32'h1);
      check("single_id",    32'(bus.resp_id), 32'h0);
      check("single_data",  bus.resp_data, 32'h0a04_0000);
      step();
      check("single_drain", 32'(bus.resp_valid), 32'h0);

      // Fresh reset so round-robin starts at requester 0 and perf counters start clean
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;

      // Round-robin with both valid: req0 ADD 1+2, req1 XOR ff^0f
      set_req(0, 32'h0000_0001, 32'h0000_0002, 4'b0001);
      set_req(1, 32'h0000_00ff, 32'h0000_000f, 4'b0101);
      bus.req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("rr_ready%0d", k), 32'(bus.req_ready), 32'(rr_ready[k]));
         step();
         check($sformatf("rr_id%0d", k),   32'(bus.resp_id), 32'(rr_id[k]));
         check($sformatf("rr_data%0d", k), bus.resp_data, rr_data[k]);
      end

      // Backpressure: req1 waits with SRL while the consumer stalls for 3 cycles
      bus.req_valid = 2'b10;
      set_req(1, 32'hfa17_0000, 32'h0000_0010, 4'b1000);
      bus.resp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_ready%0d", k), 32'(bus.req_ready), 32'h0);
         check($sformatf("bp_valid%0d", k), 32'(bus.resp_valid), 32'h1);
         check($sformatf("bp_id%0d", k),    32'(bus.resp_id), 32'h1);
         check($sformatf("bp_data%0d", k),  bus.resp_data, 32'h0000_00f0);
         step();
      end
      bus.resp_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(bus.req_ready), 32'h2);
      check("bp_release_rs1",   bus.alu_rs1, 32'hfa17_0000);
      step();
      bus.req_valid = 2'b00;
      check("bp_resp_valid", 32'(bus.resp_valid), 32'h1);
      check("bp_resp_id",    32'(bus.resp_id), 32'h1);
      check("bp_resp_data",  bus.resp_data, 32'h0000_fa17);
      step();
      check("bp_one_grant",  32'(bus.resp_valid), 32'h0);
`ifdef ALU_ARB_PERF_EN
      check("perf_grant0", 32'(perf_grant_cnt[0 +: CNT_W]),     32'd2);
      check("perf_grant1", 32'(perf_grant_cnt[CNT_W +: CNT_W]), 32'd3);
      check("perf_stall",  32'(perf_stall_cnt),                 32'd3);
`endif

      // Reset mid-operation: grant req0 (pointer moves to 1), then reset while the result is valid
      set_req(0, 32'h0000_0005, 32'h0000_0003, 4'b0010);
      bus.req_valid = 2'b01;
      step();
      check("mid_pre_valid", 32'(bus.resp_valid), 32'h1);
      rst_n         = 1'b0;
      bus.req_valid = 2'b11;
      #1;
      check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
      step();
      check("mid_rst_valid", 32'(bus.resp_valid), 32'h0);
      rst_n = 1'b1;
      #1;
      check("mid_ptr_zero", 32'(bus.req_ready), 32'h1);
      step();
      check("mid_post_id",   32'(bus.resp_id), 32'h0);
      check("mid_post_data", bus.resp_data, 32'h0000_0002);
      bus.req_valid = 2'b00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
